ram_program_loader: RTL and testbench

//  Serial-to-bus program loader: the writing end of the 8-bit RAM/MAR bus interface, which the CPU otherwise only reads.

---
 rtl/ram_program_loader_pkg.sv | 26 ++
 rtl/ram_program_loader_if.sv | 11 +
 rtl/ram_program_loader_uart_rx_8n1.sv | 84 ++++++++
 rtl/ram_program_loader.sv | 147 ++++++++++++++
 tb/tb_ram_program_loader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_program_loader_pkg.sv
// Shared types and constants for the serial program loader and its UART receiver.
// MI/RI bit positions follow the CPU control word so the loader's strobes line up with it.
package ram_program_loader_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   localparam int MI_BIT = 1;
   localparam int RI_BIT = 0;
   localparam logic [1:0] CTRL_MI = 2'(1 << MI_BIT);
   localparam logic [1:0] CTRL_RI = 2'(1 << RI_BIT);

   typedef enum logic [3:0] {
      ST_IDLE, ST_LEN, ST_DATA,
      ST_A_SET, ST_A_STB, ST_A_HLD,
      ST_D_SET, ST_D_STB, ST_D_HLD,
      ST_CHK, ST_DONE, ST_ERR
   } ld_state_t;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // A program must have at least one byte and must fit in RAM.
   function automatic logic len_ok(input logic [7:0] len, input int addr_w);
      return (len != 8'h00) && (int'(len) <= (1 << addr_w));
   endfunction

endpackage

// File: rtl/ram_program_loader_if.sv
// Write side of the CPU RAM/MAR bus: data byte, bus ownership, MI/RI selects and RAM clock strobe.
interface ram_program_loader_if;
   logic [7:0] bus_out;
   logic       bus_oe;
   logic       mi;
   logic       ri;
   logic       ld_strobe;

   modport master (output bus_out, bus_oe, mi, ri, ld_strobe);
   modport slave  (input  bus_out, bus_oe, mi, ri, ld_strobe);
endinterface

// File: rtl/ram_program_loader_uart_rx_8n1.sv
// 8N1 UART receiver, mid-bit sampling; rx_valid/rx_ferr pulse one clk after the stop-bit sample.
// No backpressure: each byte is presented for exactly one cycle.
module uart_rx_8n1
   import ram_program_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_ferr
);
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   rx_state_t   state;
   logic        rx_s1, rx_s2, rx_s3;
   logic [CW-1:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;

   always_ff @(posedge clk) begin
      if (!clr) begin
         state    <= RX_IDLE;
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_s1    <= rx;
         rx_s2    <= rx_s1;
         rx_s3    <= rx_s2;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         case (state)
            RX_IDLE: begin
               // Edge rather than level, so a line held low after a bad stop bit cannot retrigger.
               if (!rx_s2 && rx_s3) begin
                  cnt   <= '0;
                  state <= RX_START;
               end
            end
            RX_START: begin
               if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                  cnt     <= '0;
                  shreg   <= {rx_s2, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= RX_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                  cnt      <= '0;
                  rx_data  <= shreg;
                  rx_valid <= rx_s2;
                  rx_ferr  <= !rx_s2;
                  state    <= RX_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ram_program_loader.sv
// Loads a framed UART program into CPU RAM (6 clk bus write per byte) holding the CPU until the checksum passes.
// No backpressure on rx: a byte arriving during a bus write is an overrun and aborts the frame.
module ram_program_loader
   import ram_program_loader_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 5208,
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
   parameter int         ADDR_W       = 4,
   parameter int         TO_W         = 20
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 rx,
   ram_program_loader_if.master bus,
   output logic                 cpu_hold,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   ld_state_t         state;
   logic [7:0]        rx_data;
   logic              rx_valid, rx_ferr;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   cnt;
   logic [7:0]        sum, data_q, bus_q;
   logic [TO_W-1:0]   to_cnt;
   logic              ovr, oe_q, stb_q;
   logic [1:0]        ctrl_q;
   logic [7:0]        chk_sum;
   logic              waiting, in_write, to_err;

   uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk      (clk),
      .clr      (clr),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ferr  (rx_ferr)
   );

   assign bus.bus_out   = bus_q;
   assign bus.bus_oe    = oe_q;
   assign bus.mi        = ctrl_q[MI_BIT];
   assign bus.ri        = ctrl_q[RI_BIT];
   assign bus.ld_strobe = stb_q;
   assign busy          = !(state inside {ST_IDLE, ST_DONE, ST_ERR});

   always_comb begin
      chk_sum  = sum + rx_data;
      waiting  = state inside {ST_LEN, ST_DATA, ST_CHK};
      in_write = state inside {ST_A_SET, ST_A_STB, ST_A_HLD, ST_D_SET, ST_D_STB, ST_D_HLD};
      to_err   = (waiting && (rx_ferr || (to_cnt == '1)))
               || (state == ST_LEN && rx_valid && !len_ok(rx_data, ADDR_W))
               || (state == ST_CHK && rx_valid && chk_sum != 8'h00)
               || (state == ST_D_HLD && (ovr || rx_valid || rx_ferr))
               || (state == ST_DONE && rx_ferr);
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state    <= ST_IDLE;
         addr     <= '0;
         cnt      <= '0;
         sum      <= '0;
         data_q   <= '0;
         bus_q    <= '0;
         to_cnt   <= '0;
         ovr      <= 1'b0;
         oe_q     <= 1'b0;
         stb_q    <= 1'b0;
         ctrl_q   <= '0;
         cpu_hold <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         to_cnt <= (waiting && !rx_valid) ? to_cnt + 1'b1 : '0;
         if (in_write && (rx_valid || rx_ferr)) ovr <= 1'b1;
         else if (state == ST_DATA)             ovr <= 1'b0;

         if (to_err) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
            oe_q     <= 1'b0;
            stb_q    <= 1'b0;
            ctrl_q   <= '0;
            bus_q    <= '0;
         end else begin
            case (state)
               ST_IDLE, ST_DONE, ST_ERR: begin
                  if (rx_valid && rx_data == SYNC_BYTE) begin
                     state <= ST_LEN;
                     done  <= 1'b0;
                     err   <= 1'b0;
                  end
               end
               ST_LEN: begin
                  if (rx_valid) begin
                     addr     <= '0;
                     cnt      <= rx_data[ADDR_W:0];
                     sum      <= '0;
                     cpu_hold <= 1'b1;
                     state    <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (rx_valid) begin
                     data_q <= rx_data;
                     sum    <= chk_sum;
                     bus_q  <= 8'(addr);
                     oe_q   <= 1'b1;
                     ctrl_q <= CTRL_MI;
                     state  <= ST_A_SET;
                  end
               end
               ST_A_SET: begin stb_q <= 1'b1; state <= ST_A_STB; end
               ST_A_STB: begin stb_q <= 1'b0; state <= ST_A_HLD; end
               ST_A_HLD: begin
                  bus_q  <= data_q;
                  ctrl_q <= CTRL_RI;
                  state  <= ST_D_SET;
               end
               ST_D_SET: begin stb_q <= 1'b1; state <= ST_D_STB; end
               ST_D_STB: begin stb_q <= 1'b0; state <= ST_D_HLD; end
               ST_D_HLD: begin
                  oe_q   <= 1'b0;
                  ctrl_q <= '0;
                  bus_q  <= '0;
                  addr   <= addr + 1'b1;
                  cnt    <= cnt - 1'b1;
                  state  <= (cnt == (ADDR_W+1)'(1)) ? ST_CHK : ST_DATA;
               end
               ST_CHK: begin
                  if (rx_valid) begin
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ram_program_loader.sv
// Scoreboard bench: stimulus queues expected RAM writes, a bus monitor with a MAR/RAM model pops and checks them.
module tb_ram_program_loader;
   localparam int CPB = 8;

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic clr = 1'b0;
   logic rx  = 1'b1;
   logic cpu_hold, busy, done, err;

   ram_program_loader_if bus_if ();

   ram_program_loader #(
      .CLKS_PER_BIT (CPB),
      .SYNC_BYTE    (8'hA5),
      .ADDR_W       (4),
      .TO_W         (9)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .rx       (rx),
      .bus      (bus_if),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int   pass_cnt = 0;
   int   total_cnt = 0;
   wr_t  exp_q[$];
   logic [7:0] ram [16];
   logic [3:0] mar;
   int   oe_run = 0, mi_run = 0, ri_run = 0, oe_rise = 0;

   task automatic check(input string nm, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic fail_evt(input string nm);
      total_cnt++;
      $display("FAIL %s: unexpected event (t=%0t)", nm, $time);
   endtask

   // Bus monitor with MAR/RAM model: every strobe is matched against the expected-write queue.
   always @(negedge clk) begin
      if (!clr) begin
         oe_run = 0; mi_run = 0; ri_run = 0;
      end else begin
         if (bus_if.ld_strobe) begin
            check("strobe_with_oe", int'(bus_if.bus_oe), 1);
            if (bus_if.mi && !bus_if.ri) begin
               check("mi_strobe_pos", oe_run, 1);
               if (exp_q.size() == 0) fail_evt("unexpected_mar_write");
               else check("mar_addr", int'(bus_if.bus_out), int'(exp_q[0].a));
               mar = bus_if.bus_out[3:0];
            end else if (bus_if.ri && !bus_if.mi) begin
               check("ri_strobe_pos", oe_run, 4);
               if (exp_q.size() == 0) fail_evt("unexpected_ram_write");
               else begin
                  wr_t w;
                  w = exp_q.pop_front();
                  check("ram_addr", int'(mar), int'(w.a));
                  check("ram_data", int'(bus_if.bus_out), int'(w.d));
               end
               ram[mar] = bus_if.bus_out;
            end else fail_evt("strobe_ctrl_select");
         end
         if (bus_if.bus_oe) begin
            if (oe_run == 0) oe_rise++;
            oe_run++;
            mi_run += int'(bus_if.mi);
            ri_run += int'(bus_if.ri);
         end else if (oe_run != 0) begin
            check("oe_run_len", oe_run, 6);
            check("mi_run_len", mi_run, 3);
            check("ri_run_len", ri_run, 3);
            oe_run = 0; mi_run = 0; ri_run = 0;
         end
      end
   end

   task automatic do_reset();
      clr = 1'b0;
      rx  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      exp_q.delete();
      mar = '0;
      for (int i = 0; i < 16; i++) ram[i] = 8'h00;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(posedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(posedge clk);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check(nm, int'(busy), 0);
   endtask

   // Program 1E 2F E0: sum = 0x12D, so the good checksum is 0x100 - 0x2D = 0xD3.
   task automatic send_frame3(input logic [7:0] chk);
      exp_q.push_back('{a: 4'd0, d: 8'h1E});
      exp_q.push_back('{a: 4'd1, d: 8'h2F});
      exp_q.push_back('{a: 4'd2, d: 8'hE0});
      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      @(negedge clk);
      check("hold_during_frame", int'(cpu_hold), 1);
      check("busy_during_frame", int'(busy), 1);
      send_byte(8'h1E, 1'b1);
      send_byte(8'h2F, 1'b1);
      send_byte(8'hE0, 1'b1);
      send_byte(chk, 1'b1);
   endtask

   task automatic check_ram3(input string nm);
      check({nm, "_ram0"}, int'(ram[0]), 8'h1E);
      check({nm, "_ram1"}, int'(ram[1]), 8'h2F);
      check({nm, "_ram2"}, int'(ram[2]), 8'hE0);
      check({nm, "_queue_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      logic hit;

      // Reset state
      do_reset();
      check("rst_bus_out", int'(bus_if.bus_out), 0);
      check("rst_bus_oe", int'(bus_if.bus_oe), 0);
      check("rst_mi", int'(bus_if.mi), 0);
      check("rst_ri", int'(bus_if.ri), 0);
      check("rst_ld_strobe", int'(bus_if.ld_strobe), 0);
      check("rst_cpu_hold", int'(cpu_hold), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);

      // Good frame
      send_frame3(8'hD3);
      wait_idle("good_idle");
      check("good_done", int'(done), 1);
      check("good_err", int'(err), 0);
      check("good_hold_released", int'(cpu_hold), 0);
      check_ram3("good");

      // Bad checksum, then recovery with a good frame
      do_reset();
      send_frame3(8'h00);
      wait_idle("badchk_idle");
      check("badchk_err", int'(err), 1);
      check("badchk_done", int'(done), 0);
      check("badchk_hold", int'(cpu_hold), 1);
      check_ram3("badchk");
      send_frame3(8'hD3);
      wait_idle("resend_idle");
      check("resend_done", int'(done), 1);
      check("resend_err", int'(err), 0);
      check("resend_hold", int'(cpu_hold), 0);

      // Length boundaries: 0 and 17 rejected without touching the bus
      do_reset();
      base = oe_rise;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      check("len0_err", int'(err), 1);
      check("len0_no_bus", oe_rise - base, 0);
      do_reset();
      base = oe_rise;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h11, 1'b1);
      check("len17_err", int'(err), 1);
      check("len17_no_bus", oe_rise - base, 0);

      // Framing error on second data byte
      do_reset();
      exp_q.push_back('{a: 4'd0, d: 8'h11});
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b0);
      check("ferr_err", int'(err), 1);
      check("ferr_ram0", int'(ram[0]), 8'h11);
      check("ferr_queue_drained", exp_q.size(), 0);

      // Junk byte while idle
      do_reset();
      send_byte(8'h55, 1'b1);
      check("junk_err", int'(err), 0);
      check("junk_busy", int'(busy), 0);
      check("junk_done", int'(done), 0);

      // Inter-byte timeout (2**9 clk) after LEN
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      for (int n = 0; n < 1500 && !err; n++) @(negedge clk);
      check("timeout_err", int'(err), 1);
      check("timeout_hold", int'(cpu_hold), 1);
      check("timeout_busy", int'(busy), 0);

      // Reset asserted during the address strobe
      do_reset();
      exp_q.push_back('{a: 4'd0, d: 8'h7C});
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      hit = 1'b0;
      fork
         send_byte(8'h7C, 1'b1);
         begin
            for (int n = 0; n < 400 && !hit; n++) begin
               @(negedge clk);
               if (bus_if.ld_strobe && bus_if.mi) begin
                  hit = 1'b1;
                  clr = 1'b0;
               end
            end
         end
      join
      check("abort_strobe_seen", int'(hit), 1);
      if (!hit) clr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_bus_oe", int'(bus_if.bus_oe), 0);
      check("abort_ld_strobe", int'(bus_if.ld_strobe), 0);
      check("abort_busy", int'(busy), 0);
      do_reset();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
